vram_vga_scanner: RTL and testbench

//  Display back end of mide_cpu: scans the VRAM image (row-major, 8-bit grayscale) over the GPU read port.
//  - drives gpu_address, consumes vram_out, and produces 640x480@60 VGA timing plus an 8-bit pixel.
//  - image is placed in a fixed window; everything else in the active area is background.

---
 rtl/vram_vga_scanner.sv | 166 ++++++++++++++++
 tb/tb_vram_vga_scanner.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_vga_scanner.sv
// vram_vga_scanner: display back end that scans a row-major 8-bit grayscale
// VRAM image over a read port and produces VGA timing plus one pixel per tick.
// The image sits in a fixed window; the rest of the active area is background.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high
//   gpu_address  VRAM read address (row-major pixel index inside the window)
//   vram_out     VRAM read data for gpu_address, valid READ_LATENCY clks later
//   hsync        horizontal sync, active-low (registered)
//   vsync        vertical sync, active-low (registered)
//   blank_n      1 during active video (registered)
//   rgb_out      grayscale pixel (registered)
//   frame_start  one-clk pulse when the scan wraps to (0,0)
//
// Optional feature: define DISPLAY_BORDER_EN to draw a 1-pixel 8'hFF frame
// around the image window. Without it those pixels show BG_COLOR.
// The H_*/V_* parameters default to 640x480@60 timing.
module vram_vga_scanner #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned IMG_W        = 300,
    parameter int unsigned IMG_H        = 300,
    parameter int unsigned IMG_X0       = 170,
    parameter int unsigned IMG_Y0       = 90,
    parameter logic [7:0]  BG_COLOR     = 8'h00,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] gpu_address,
    input  logic [7:0]  vram_out,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  rgb_out,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W          = $clog2(H_TOTAL);
    localparam int unsigned V_W          = $clog2(V_TOTAL);
    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned IMG_X1       = IMG_X0 + IMG_W;
    localparam int unsigned IMG_Y1       = IMG_Y0 + IMG_H;

    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic [31:0]      pix_idx;
    logic [7:0]       pix_data;

    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             frame_wrap;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             active;
    logic             in_win;
    logic [7:0]       pix_sample;
    logic [7:0]       rgb_next;
`ifdef DISPLAY_BORDER_EN
    logic             on_border;
`endif

    // Pixel tick and counter wrap conditions
    always_comb begin
        tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
        h_last     = (h_cnt == H_W'(H_TOTAL - 1));
        v_last     = (v_cnt == V_W'(V_TOTAL - 1));
        frame_wrap = h_last && v_last;
    end

    // Raw sync/blank/window decode for the pixel under the counters
    always_comb begin
        hsync_raw = !((h_cnt >= H_W'(H_SYNC_START)) && (h_cnt < H_W'(H_SYNC_END)));
        vsync_raw = !((v_cnt >= V_W'(V_SYNC_START)) && (v_cnt < V_W'(V_SYNC_END)));
        active    = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
        in_win    = (h_cnt >= H_W'(IMG_X0)) && (h_cnt < H_W'(IMG_X1)) &&
                    (v_cnt >= V_W'(IMG_Y0)) && (v_cnt < V_W'(IMG_Y1));
    end

`ifdef DISPLAY_BORDER_EN
    // Ring one pixel outside the window: the expanded rectangle minus the window
    always_comb begin
        on_border = active && !in_win &&
                    (h_cnt >= H_W'(IMG_X0 - 1)) && (h_cnt <= H_W'(IMG_X1)) &&
                    (v_cnt >= V_W'(IMG_Y0 - 1)) && (v_cnt <= V_W'(IMG_Y1));
    end
`endif

    // Read data is captured on the first clk it is valid, so the port only
    // has to present it for one clk rather than until the tick.
    always_comb begin
        pix_sample = (div_cnt == DIV_W'(READ_LATENCY)) ? vram_out : pix_data;
    end

    // Pixel colour selection
    always_comb begin
        rgb_next = 8'h00;
        if (in_win) begin
            rgb_next = pix_sample;
`ifdef DISPLAY_BORDER_EN
        end else if (on_border) begin
            rgb_next = 8'hFF;
`endif
        end else if (active) begin
            rgb_next = BG_COLOR;
        end
    end

    // Divider, timing counters, address generator and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pix_idx     <= 32'd0;
            pix_data    <= 8'h00;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            rgb_out     <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            pix_data    <= pix_sample;
            if (tick) begin
                div_cnt <= '0;
                h_cnt   <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last) begin
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end
                // Wrap wins over increment; outside the window the index holds
                if (frame_wrap) begin
                    pix_idx <= 32'd0;
                end else if (in_win) begin
                    pix_idx <= pix_idx + 32'd1;
                end
                hsync       <= hsync_raw;
                vsync       <= vsync_raw;
                blank_n     <= active;
                rgb_out     <= rgb_next;
                frame_start <= frame_wrap;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign gpu_address = pix_idx;

endmodule

// File: tb/tb_vram_vga_scanner.sv
// Bench for vram_vga_scanner. A reduced-geometry instance (small timing and
// window) is checked against a reference model derived from elapsed clocks;
// a default-parameter instance is used for full 640x480 line timing.
module tb_vram_vga_scanner;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned IMG_W   = 12;
    localparam int unsigned IMG_H   = 10;
    localparam int unsigned IMG_X0  = 10;
    localparam int unsigned IMG_Y0  = 8;
    localparam logic [7:0]  BG      = 8'h40;
    localparam int unsigned HA = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int unsigned VA = 30, VFP = 2, VS = 2, VBP = 3;
    localparam int unsigned HT  = HA + HFP + HS + HBP;
    localparam int unsigned VT  = VA + VFP + VS + VBP;
    localparam int unsigned FT  = HT * VT;
    localparam int unsigned FTC = FT * CLK_DIV;

    typedef struct packed {
        logic [31:0] gpu;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [7:0]  rgb;
        logic        fs;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpu_s, gpu_f;
    logic [7:0]  vram_s, vram_f;
    logic        hs_s, vs_s, bl_s, fs_s;
    logic        hs_f, vs_f, bl_f, fs_f;
    logic [7:0]  rgb_s, rgb_f;

    logic [7:0]  mem [256];
    int unsigned edges;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    vram_vga_scanner #(
        .CLK_DIV(CLK_DIV), .READ_LATENCY(1), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0), .BG_COLOR(BG),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .gpu_address(gpu_s), .vram_out(vram_s),
        .hsync(hs_s), .vsync(vs_s), .blank_n(bl_s), .rgb_out(rgb_s),
        .frame_start(fs_s)
    );

    vram_vga_scanner dut_full (
        .clk(clk), .reset(reset), .gpu_address(gpu_f), .vram_out(vram_f),
        .hsync(hs_f), .vsync(vs_f), .blank_n(bl_f), .rgb_out(rgb_f),
        .frame_start(fs_f)
    );

    // VRAM models, read latency 1
    always @(posedge clk) vram_s <= mem[gpu_s[7:0]];
    always @(posedge clk) vram_f <= gpu_f[7:0];

    // Clock edges since reset release: the model's notion of time
    always @(posedge clk) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // Number of window pixels scanned before frame position q
    function automatic int unsigned win_count(input int unsigned q);
        int unsigned h, v;
        h = q % HT;
        v = q / HT;
        if (v < IMG_Y0) return 0;
        if (v >= IMG_Y0 + IMG_H) return IMG_W * IMG_H;
        if (h < IMG_X0) return (v - IMG_Y0) * IMG_W;
        if (h >= IMG_X0 + IMG_W) return (v - IMG_Y0 + 1) * IMG_W;
        return (v - IMG_Y0) * IMG_W + (h - IMG_X0);
    endfunction

    // Expected outputs after e clock edges since reset release
    function automatic obs_t model(input int unsigned e);
        obs_t        o;
        int unsigned m, p, h, v;
        logic        inw;
        m     = e / CLK_DIV;
        o.gpu = 32'(win_count(m % FT));
        o.hs  = 1'b1;
        o.vs  = 1'b1;
        o.bl  = 1'b0;
        o.rgb = 8'h00;
        o.fs  = 1'b0;
        if (m != 0) begin
            p    = (m - 1) % FT;
            h    = p % HT;
            v    = p / HT;
            o.hs = !(h >= HA + HFP && h < HA + HFP + HS);
            o.vs = !(v >= VA + VFP && v < VA + VFP + VS);
            o.bl = (h < HA) && (v < VA);
            inw  = (h >= IMG_X0) && (h < IMG_X0 + IMG_W) &&
                   (v >= IMG_Y0) && (v < IMG_Y0 + IMG_H);
            if (inw) o.rgb = mem[8'(win_count(p))];
`ifdef DISPLAY_BORDER_EN
            else if (o.bl && h + 1 >= IMG_X0 && h <= IMG_X0 + IMG_W &&
                     v + 1 >= IMG_Y0 && v <= IMG_Y0 + IMG_H) o.rgb = 8'hFF;
`endif
            else if (o.bl) o.rgb = BG;
            o.fs = (e % CLK_DIV == 0) && (m % FT == 0);
        end
        return o;
    endfunction

    function automatic int unsigned qpos(input int unsigned v, input int unsigned h);
        return v * HT + h;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic goto_edge(input int unsigned target);
        for (int k = 0; k < 120000 && edges < target; k++) step();
        tests++;
        if (edges != target) begin
            fails++;
            $display("FAIL goto_edge: reached %0d, required %0d", edges, target);
        end
    endtask

    task automatic test_reset();
        obs_t exp_r, got;
        exp_r = '{gpu: 32'd0, hs: 1'b1, vs: 1'b1, bl: 1'b0, rgb: 8'h00, fs: 1'b0};
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = '{gpu: gpu_s, hs: hs_s, vs: vs_s, bl: bl_s, rgb: rgb_s, fs: fs_s};
        tests++;
        if (got !== exp_r) begin
            fails++;
            $display("FAIL reset_small: got %h, required %h", got, exp_r);
        end
        got = '{gpu: gpu_f, hs: hs_f, vs: vs_f, bl: bl_f, rgb: rgb_f, fs: fs_f};
        tests++;
        if (got !== exp_r) begin
            fails++;
            $display("FAIL reset_full: got %h, required %h", got, exp_r);
        end
        reset = 1'b0;
        step();
        tests++;
        if (bl_s !== 1'b0 || rgb_s !== 8'h00) begin
            fails++;
            $display("FAIL pre_first_tick: blank_n=%b rgb=%h, required 0 00", bl_s, rgb_s);
        end
        step();
        tests++;
        if (bl_s !== 1'b1 || rgb_s !== BG || gpu_s !== 32'd0 || bl_f !== 1'b1) begin
            fails++;
            $display("FAIL first_tick: blank_n=%b rgb=%h gpu=%0d full_blank_n=%b, required 1 %h 0 1",
                     bl_s, rgb_s, gpu_s, bl_f, BG);
        end
    endtask

    task automatic test_line_timing();
        int unsigned falls[$];
        int unsigned hs_low, bl_high, vs_low;
        logic        prev_hs;
        hs_low = 0; bl_high = 0; vs_low = 0; prev_hs = 1'b1;
        apply_reset(3);
        for (int i = 0; i < 3300; i++) begin
            step();
            if (prev_hs && !hs_f) falls.push_back(edges);
            prev_hs = hs_f;
            if (edges <= 1600 && !hs_f) hs_low++;
            if (edges <= 1600 && bl_f) bl_high++;
            if (!vs_f) vs_low++;
        end
        tests++;
        if (falls.size() < 2) begin
            fails++;
            $display("FAIL hsync_falls: saw %0d falling edges, required at least 2", falls.size());
        end else begin
            tests++;
            if (falls[0] != 1314) begin
                fails++;
                $display("FAIL hsync_fall_pos: at clk %0d, required 1314", falls[0]);
            end
            tests++;
            if (falls[1] - falls[0] != 1600) begin
                fails++;
                $display("FAIL line_period: %0d clks, required 1600", falls[1] - falls[0]);
            end
        end
        tests++;
        if (hs_low != 192) begin
            fails++;
            $display("FAIL hsync_width: %0d clks, required 192", hs_low);
        end
        tests++;
        if (bl_high != 1280 || vs_low != 0) begin
            fails++;
            $display("FAIL line_active: blank_n high %0d vsync low %0d, required 1280 0", bl_high, vs_low);
        end
    endtask

    task automatic test_frame_timing();
        int unsigned pulses[$];
        int unsigned vs_low;
        vs_low = 0;
        apply_reset(2);
        for (int i = 0; i < 3 * FTC + 8; i++) begin
            step();
            if (fs_s) pulses.push_back(edges);
            if (!vs_s && edges <= FTC) vs_low++;
        end
        tests++;
        if (pulses.size() != 3) begin
            fails++;
            $display("FAIL frame_pulses: %0d high clks, required 3", pulses.size());
        end else begin
            tests++;
            if (pulses[0] != FTC || pulses[1] - pulses[0] != FTC || pulses[2] - pulses[1] != FTC) begin
                fails++;
                $display("FAIL frame_period: pulses at %0d %0d %0d, required %0d %0d %0d",
                         pulses[0], pulses[1], pulses[2], FTC, 2 * FTC, 3 * FTC);
            end
        end
        tests++;
        if (vs_low != VS * HT * CLK_DIV) begin
            fails++;
            $display("FAIL vsync_width: %0d clks, required %0d", vs_low, VS * HT * CLK_DIV);
        end
    endtask

    task automatic test_window_points();
        int unsigned q;
        apply_reset(2);
        goto_edge((qpos(2, 2) + 1) * CLK_DIV);
        tests++;
        if (rgb_s !== BG || bl_s !== 1'b1) begin
            fails++;
            $display("FAIL background: rgb=%h blank_n=%b, required %h 1", rgb_s, bl_s, BG);
        end
        goto_edge((qpos(2, HA + 10) + 1) * CLK_DIV);
        tests++;
        if (rgb_s !== 8'h00 || bl_s !== 1'b0) begin
            fails++;
            $display("FAIL blanking: rgb=%h blank_n=%b, required 00 0", rgb_s, bl_s);
        end
        goto_edge((qpos(IMG_Y0 - 1, IMG_X0 - 1) + 1) * CLK_DIV);
        tests++;
`ifdef DISPLAY_BORDER_EN
        if (rgb_s !== 8'hFF) begin
            fails++;
            $display("FAIL border_tl: rgb=%h, required ff", rgb_s);
        end
`else
        if (rgb_s !== BG) begin
            fails++;
            $display("FAIL border_tl: rgb=%h, required %h", rgb_s, BG);
        end
`endif
        q = qpos(IMG_Y0, IMG_X0);
        goto_edge(q * CLK_DIV);
        tests++;
        if (gpu_s !== 32'd0) begin
            fails++;
            $display("FAIL addr_first: gpu=%0d, required 0", gpu_s);
        end
        goto_edge((q + 1) * CLK_DIV);
        tests++;
        if (rgb_s !== mem[0]) begin
            fails++;
            $display("FAIL rgb_first: rgb=%h, required %h", rgb_s, mem[0]);
        end
        goto_edge(qpos(IMG_Y0, IMG_X0 + IMG_W - 1) * CLK_DIV);
        tests++;
        if (gpu_s !== 32'(IMG_W - 1)) begin
            fails++;
            $display("FAIL addr_row_end: gpu=%0d, required %0d", gpu_s, IMG_W - 1);
        end
        goto_edge(qpos(IMG_Y0 + 1, IMG_X0) * CLK_DIV);
        tests++;
        if (gpu_s !== 32'(IMG_W)) begin
            fails++;
            $display("FAIL addr_row2: gpu=%0d, required %0d", gpu_s, IMG_W);
        end
        q = qpos(IMG_Y0 + IMG_H - 1, IMG_X0 + IMG_W - 1);
        goto_edge(q * CLK_DIV);
        tests++;
        if (gpu_s !== 32'(IMG_W * IMG_H - 1)) begin
            fails++;
            $display("FAIL addr_last: gpu=%0d, required %0d", gpu_s, IMG_W * IMG_H - 1);
        end
        goto_edge((q + 1) * CLK_DIV);
        tests++;
        if (rgb_s !== mem[IMG_W * IMG_H - 1] || gpu_s !== 32'(IMG_W * IMG_H)) begin
            fails++;
            $display("FAIL last_pixel: rgb=%h gpu=%0d, required %h %0d",
                     rgb_s, gpu_s, mem[IMG_W * IMG_H - 1], IMG_W * IMG_H);
        end
        goto_edge((qpos(IMG_Y0 + IMG_H, IMG_X0 + IMG_W) + 1) * CLK_DIV);
        tests++;
`ifdef DISPLAY_BORDER_EN
        if (rgb_s !== 8'hFF) begin
            fails++;
            $display("FAIL border_br: rgb=%h, required ff", rgb_s);
        end
`else
        if (rgb_s !== BG) begin
            fails++;
            $display("FAIL border_br: rgb=%h, required %h", rgb_s, BG);
        end
`endif
        goto_edge(qpos(IMG_Y0 + IMG_H + 2, 0) * CLK_DIV);
        tests++;
        if (gpu_s !== 32'(IMG_W * IMG_H)) begin
            fails++;
            $display("FAIL addr_hold: gpu=%0d, required %0d", gpu_s, IMG_W * IMG_H);
        end
    endtask

    task automatic test_mid_frame_reset();
        int unsigned first_fs;
        apply_reset(2);
        goto_edge(qpos(IMG_Y0 + 5, IMG_X0 + 3) * CLK_DIV);
        tests++;
        if (gpu_s !== 32'(5 * IMG_W + 3)) begin
            fails++;
            $display("FAIL mid_addr: gpu=%0d, required %0d", gpu_s, 5 * IMG_W + 3);
        end
        apply_reset(2);
        tests++;
        if (gpu_s !== 32'd0 || bl_s !== 1'b0 || hs_s !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: gpu=%0d blank_n=%b hsync=%b, required 0 0 1", gpu_s, bl_s, hs_s);
        end
        first_fs = 0;
        for (int i = 0; i < FTC + 20 && first_fs == 0; i++) begin
            step();
            if (fs_s) first_fs = edges;
        end
        tests++;
        if (first_fs != FTC || gpu_s !== 32'd0) begin
            fails++;
            $display("FAIL mid_restart: frame_start at %0d gpu=%0d, required %0d 0", first_fs, gpu_s, FTC);
        end
    endtask

    task automatic test_random_scan();
        obs_t got, exp_o;
        int   local_fails;
        int   len;
        local_fails = 0;
        for (int seg = 0; seg < 5 && local_fails < 8; seg++) begin
            reset = 1'b1;
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            apply_reset(int'($urandom_range(1, 3)));
            len = int'($urandom_range(300, 6000));
            for (int i = 0; i <= len && local_fails < 8; i++) begin
                if (i != 0) step();
                got   = '{gpu: gpu_s, hs: hs_s, vs: vs_s, bl: bl_s, rgb: rgb_s, fs: fs_s};
                exp_o = model(edges);
                tests++;
                if (got !== exp_o) begin
                    fails++;
                    local_fails++;
                    $display("FAIL scan seg %0d clk %0d: got gpu=%0d hs=%b vs=%b bl=%b rgb=%h fs=%b, required gpu=%0d hs=%b vs=%b bl=%b rgb=%h fs=%b",
                             seg, edges, got.gpu, got.hs, got.vs, got.bl, got.rgb, got.fs,
                             exp_o.gpu, exp_o.hs, exp_o.vs, exp_o.bl, exp_o.rgb, exp_o.fs);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_window_points();
        test_mid_frame_reset();
        test_random_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: cycle budget exceeded, required completion within 90000 clks");
        $fatal(1, "watchdog");
    end

endmodule
